// File: rtl/axi_sched_pkg.sv
// Shared types and width helpers for the per-slave AXI access scheduler.
package axi_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_R = 2'd1,
    GNT_W = 2'd2
  } sched_state_t;

  localparam int unsigned WDOG_W = 16;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: the first set bit of i_elig above i_ptr
// wins, wrapping around to index 0, so the master at i_ptr itself is last.
module rr_pick
  import axi_sched_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  i_elig,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_idx,
  output logic [N-1:0]  o_onehot
);

  localparam int unsigned CW = IW + 1;

  // Two passes instead of a modulo rotate: indices above the pointer first,
  // then the wrap-around from 0 up to and including the pointer.
  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    o_found  = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (!o_found && i_elig[i] && (CW'(i) > {1'b0, i_ptr})) begin
        o_found     = 1'b1;
        o_idx       = IW'(i);
        o_onehot[i] = 1'b1;
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (!o_found && i_elig[i] && (CW'(i) <= {1'b0, i_ptr})) begin
        o_found     = 1'b1;
        o_idx       = IW'(i);
        o_onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_slave_rr_scheduler.sv
// Per-slave round-robin scheduler: one grant per transaction, released on the
// R-last or B handshake, or forcibly by the watchdog.
module axi_slave_rr_scheduler
  import axi_sched_pkg::*;
#(
  parameter int unsigned NUM_M   = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [NUM_M-1:0]         req,
  input  logic [NUM_M-1:0]         req_rd,
  input  logic [NUM_M-1:0]         blk,
  input  logic                     end_r,
  input  logic                     end_w,
  output logic [NUM_M-1:0]         grant,
  output logic [$clog2(NUM_M)-1:0] grant_id,
  output logic                     grant_rd,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int unsigned IW = idx_width(NUM_M);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  sched_state_t      r_state, w_state;
  logic [NUM_M-1:0]  r_grant, w_grant;
  logic [IW-1:0]     r_grant_id, w_grant_id;
  logic              r_grant_rd, w_grant_rd;
  logic              r_timeout_err, w_timeout_err;
  logic [IW-1:0]     r_rr_ptr, w_rr_ptr;
  logic [WDOG_W-1:0] r_wdog, w_wdog;

  logic              w_arb;
  logic              w_found;
  logic [IW-1:0]     w_win;
  logic [NUM_M-1:0]  w_onehot;

  rr_pick #(.N(NUM_M), .IW(IW)) u_pick (
    .i_elig   (req & ~blk),
    .i_ptr    (r_rr_ptr),
    .o_found  (w_found),
    .o_idx    (w_win),
    .o_onehot (w_onehot)
  );

  always_comb begin
    w_state       = r_state;
    w_grant       = r_grant;
    w_grant_id    = r_grant_id;
    w_grant_rd    = r_grant_rd;
    w_rr_ptr      = r_rr_ptr;
    w_wdog        = r_wdog;
    w_timeout_err = 1'b0;
    w_arb         = 1'b0;
    case (r_state)
      IDLE: w_arb = 1'b1;
      GNT_R, GNT_W: begin
        // A normal end wins over a watchdog expiry in the same cycle.
        if ((r_state == GNT_R) ? end_r : end_w) begin
          w_arb = 1'b1;
        end else if (r_wdog == WDOG_LAST) begin
          w_state       = IDLE;
          w_grant       = '0;
          w_grant_id    = '0;
          w_grant_rd    = 1'b0;
          w_wdog        = '0;
          w_timeout_err = 1'b1;
          w_rr_ptr      = r_grant_id;
        end else begin
          w_wdog = r_wdog + 1'b1;
        end
      end
      default: begin
        w_state    = IDLE;
        w_grant    = '0;
        w_grant_id = '0;
        w_grant_rd = 1'b0;
        w_wdog     = '0;
      end
    endcase

    if (w_arb) begin
      w_wdog = '0;
      if (w_found) begin
        w_state    = req_rd[w_win] ? GNT_R : GNT_W;
        w_grant    = w_onehot;
        w_grant_id = w_win;
        w_grant_rd = req_rd[w_win];
        w_rr_ptr   = w_win;
      end else begin
        w_state    = IDLE;
        w_grant    = '0;
        w_grant_id = '0;
        w_grant_rd = 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_grant_rd    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_rr_ptr      <= IW'(NUM_M - 1);
      r_wdog        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state       <= w_state;
      r_grant       <= w_grant;
      r_grant_id    <= w_grant_id;
      r_grant_rd    <= w_grant_rd;
      r_timeout_err <= w_timeout_err;
      r_rr_ptr      <= w_rr_ptr;
      r_wdog        <= w_wdog;
    end
  end

  assign grant       = r_grant;
  assign grant_id    = r_grant_id;
  assign grant_rd    = r_grant_rd;
  assign busy        = |r_grant;
  assign timeout_err = r_timeout_err;

endmodule

// File: doc/axi_slave_rr_scheduler.md
Name: axi_slave_rr_scheduler

Overview:
- Per-slave access scheduler for the AXI interconnect. Shares one slave port between NUM_M masters using round-robin priority.
- Each grant is held for exactly one transaction. A read grant ends on the R-last handshake; a write grant ends on the B handshake.
- A watchdog forcibly releases a slave that never completes its transaction.
- One instance per slave. It drives the mux selects of the address, data and response channel muxes.

Parameters:
- NUM_M, 3, number of masters competing for this slave (2..8)
- TIMEOUT, 255, cycles a grant may stay open without its end handshake before forced release (1..65535)

Ports:
- ACLK  input  1  clock
- ARESETn  input  1  asynchronous active-low reset
- req  input  NUM_M  per-master request, level, held until granted
- req_rd  input  NUM_M  per-master direction: 1 = read, 0 = write
- blk  input  NUM_M  per-master block. A blocked master is not eligible this cycle (used when the master is already active on another slave).
- end_r  input  1  RVALID&RREADY&RLAST on this slave
- end_w  input  1  BVALID&BREADY on this slave
- grant  output  NUM_M  one-hot grant, registered
- grant_id  output  $clog2(NUM_M)  index of the granted master; 0 when idle
- grant_rd  output  1  direction of the current grant: 1 = read, 0 = write; 0 when idle
- busy  output  1  slave currently granted
- timeout_err  output  1  one-cycle pulse when the watchdog forces a release

Behaviour:
- Reset (asynchronous, any time, including mid-burst):
  - state=IDLE; grant=0, grant_id=0, grant_rd=0, busy=0, timeout_err=0.
  - rr_ptr=NUM_M-1, so master 0 has top priority after reset.
  - Watchdog counter=0.
- States:
  - IDLE: no grant.
  - GNT_R: read grant held.
  - GNT_W: write grant held.
- Eligibility: elig[i] = req[i] & ~blk[i].
- Arbitration:
  - Scan eligible masters starting at index (rr_ptr+1) mod NUM_M, wrapping around.
  - The first eligible master wins. rr_ptr is loaded with the winner index on the grant edge.
- IDLE:
  - If any master is eligible: go to GNT_R if req_rd[winner]=1, else GNT_W.
  - Grant registers update on the same edge, so latency is 1 cycle from req to grant.
- GNT_R:
  - Stay until end_r=1. end_w is ignored.
- GNT_W:
  - Stay until end_w=1. end_r is ignored.
- On the end handshake:
  - Re-arbitrate in the same cycle, with rotated priority so the just-finished master is last.
  - If a master is eligible, the next grant is loaded on that edge, giving back-to-back grants with no idle cycle. Otherwise go to IDLE.
  - A master that keeps requesting is re-granted only if no other master is eligible.
- req and req_rd are sampled only at arbitration. Changes while granted are ignored.
- Watchdog:
  - The counter increments each cycle while in a GNT state without the matching end.
  - The counter clears on entry to a GNT state and on release.
  - When the counter reaches TIMEOUT, on that edge:
    - Force state to IDLE and drop grant.
    - Pulse timeout_err for exactly one cycle.
    - Advance rr_ptr to the timed-out master.
    - No same-cycle re-grant; arbitration resumes the next cycle.
- An end handshake in the same cycle the counter reaches TIMEOUT counts as a normal end: no timeout_err.
- Invariants:
  - grant is always one-hot or zero.
  - busy = |grant.
  - grant_id and grant_rd are consistent with grant.
- Illegal state encoding: recovers to IDLE with outputs cleared.

Decomposition:
- Shared package axi_sched_pkg:
  - sched_state_t enum {IDLE, GNT_R, GNT_W}.
  - Localparam helper for index width.
- One sub-module: rr_pick.
  - Combinational rotate-priority picker.
  - Inputs: elig vector, pointer.
  - Outputs: found flag, winner index, one-hot.
  - Reusable by the interconnect's master-side decoders.

Test Plan:
1. Reset, NUM_M=3, req=3'b111 with all reads; end_r pulsed every 4th cycle -> grant_id sequence 0,1,2,0; grant is one-hot the cycle after each end, with no IDLE gap.
2. Only master 1 requests a write; end_r pulsed, then end_w pulsed -> GNT_W holds through the end_r pulse and releases on end_w. Master 1 is re-granted next edge if still requesting.
3. blk=3'b001 and req=3'b011 from IDLE -> master 1 granted. After blk clears and master 1 ends, master 0 is granted.
4. TIMEOUT=8; grant master 2, never end -> release after 8 granted cycles. timeout_err is high for exactly 1 cycle, and the next grant goes to master 0 over master 2.
5. end_w asserted in the same cycle the counter reaches TIMEOUT -> no timeout_err, normal rotation.
6. ARESETn asserted mid-GNT_R -> outputs are 0 immediately (asynchronously). After release with req=3'b110, master 1 is granted first.
